rs232in_fifo: RTL



---
 rtl/rs232in_fifo.sv | 104 ++++++++++
 1 files changed

// File: rtl/rs232in_fifo.sv
// rtl/rs232in_fifo.sv - first-word-fall-through receive byte FIFO behind rs232in with sticky overrun.
// Optional RTS hysteresis is compiled in with `define RS232IN_FIFO_FLOWCTRL_EN.
module rs232in_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int HIGH_WATER = 12,
  parameter int LOW_WATER  = 4
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  rs232in_attention,
  input  logic [7:0]            rs232in_data,
  input  logic                  rd,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overrun,
  input  logic                  overrun_clr,
  output logic                  rts_n
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] ONE        = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] ZERO       = '0;

  if (LOW_WATER >= HIGH_WATER) begin : g_bad_water_marks
  end

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2:0]   wr_ptr;
  logic [DEPTH_LOG2:0]   rd_ptr;
  logic [DEPTH_LOG2:0]   wr_ptr_n;
  logic [DEPTH_LOG2:0]   rd_ptr_n;
  logic [DEPTH_LOG2:0]   count_n;
  logic [7:0]            head_n;
  logic                  full;
  logic                  pop;
  logic                  push;
  logic                  drop;

  always_comb begin
    full     = (count == FULL_LEVEL);
    pop      = rd & rd_valid;
    push     = rs232in_attention & (~full | pop);
    drop     = rs232in_attention & full & ~pop;
    wr_ptr_n = push ? wr_ptr + ONE : wr_ptr;
    rd_ptr_n = pop  ? rd_ptr + ONE : rd_ptr;
    count_n  = count;
    case ({push, pop})
      2'b10:   count_n = count + ONE;
      2'b01:   count_n = count - ONE;
      default: count_n = count;
    endcase
    // The incoming byte becomes the head only when it lands in the slot the read pointer moves to.
    if (push && (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr_n[DEPTH_LOG2-1:0]))
      head_n = rs232in_data;
    else
      head_n = mem[rd_ptr_n[DEPTH_LOG2-1:0]];
  end

  always_ff @(posedge clock) begin
    if (!rst && push)
      mem[wr_ptr[DEPTH_LOG2-1:0]] <= rs232in_data;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      wr_ptr   <= ZERO;
      rd_ptr   <= ZERO;
      count    <= ZERO;
      rd_valid <= 1'b0;
      rd_data  <= 8'h00;
      overrun  <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      rd_valid <= (count_n != ZERO);
      if (count_n != ZERO)
        rd_data <= head_n;
      if (drop)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end

`ifdef RS232IN_FIFO_FLOWCTRL_EN
  localparam logic [DEPTH_LOG2:0] HIGH_LEVEL = HIGH_WATER[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LOW_LEVEL  = LOW_WATER[DEPTH_LOG2:0];

  always_ff @(posedge clock) begin
    if (rst)
      rts_n <= 1'b0;
    else if (count_n >= HIGH_LEVEL)
      rts_n <= 1'b1;
    else if (count_n <= LOW_LEVEL)
      rts_n <= 1'b0;
  end
`else
  assign rts_n = 1'b0;
`endif

endmodule
